eth_demux_sel_ctrl: RTL

Frame-steering controller for the Ethernet demultiplexer. It snoops the demux input header and payload handshakes and classifies each frame by EtherType against a programmable rule table. It drives the demux `enable`, `drop` and `select` controls and holds them stable from header acceptance to the final payload beat. Optional saturating per-output frame counters and a drop counter are included.

---
 rtl/eth_demux_sel_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/eth_demux_sel_ctrl.sv
// eth_demux_sel_ctrl
// Steering controller for the Ethernet demultiplexer. It watches the header and
// payload handshakes of the demux input and looks up the header EtherType in a
// small programmable rule table. The resulting select/drop decision is held
// stable from header acceptance until the final payload beat.
// Optional statistics (per-output frame counters and a drop counter) are built
// only when the macro ETH_DEMUX_SEL_CTRL_STATS_EN is defined. Otherwise the count
// outputs are tied to zero.
module eth_demux_sel_ctrl #(
   parameter int M_COUNT      = 4,
   parameter int DEFAULT_DROP = 1,
   parameter int DEFAULT_PORT = 0,
   parameter int CNT_WIDTH    = 32,
   localparam int SEL_W       = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_eth_hdr_valid,
   input  logic                         s_eth_hdr_ready,
   input  logic [15:0]                  s_eth_type,
   input  logic                         s_eth_payload_axis_tvalid,
   input  logic                         s_eth_payload_axis_tready,
   input  logic                         s_eth_payload_axis_tlast,
   input  logic                         ctrl_enable,
   input  logic                         cfg_we,
   input  logic [SEL_W-1:0]             cfg_addr,
   input  logic [15:0]                  cfg_ethertype,
   input  logic                         cfg_rule_valid,
   output logic                         enable,
   output logic                         drop,
   output logic [SEL_W-1:0]             select,
   output logic                         busy,
   input  logic                         stats_clear,
   output logic [M_COUNT*CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0]         drop_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] FRAME = 2'd2;

   localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_PORT);
   localparam logic             DEF_DROP = (DEFAULT_DROP != 0);

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] select_q, select_d;
   logic             drop_q, drop_d;

   logic [M_COUNT-1:0] ruleValid_q;
   logic [15:0]        ruleType_q [M_COUNT];

   logic             matchHit;
   logic [SEL_W-1:0] matchIdx;
   logic             hdrAccept;
   logic             tlastAccept;
   logic             countEvent;

   assign hdrAccept   = s_eth_hdr_valid && s_eth_hdr_ready;
   assign tlastAccept = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready &&
                        s_eth_payload_axis_tlast;
   assign countEvent  = (state_q == ARMED) && hdrAccept;

   // Rule table; a write lands at the clock edge, so a lookup in the same cycle
   // still sees the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ruleValid_q <= '0;
         for (int i = 0; i < M_COUNT; i++) begin
            ruleType_q[i] <= '0;
         end
      end else if (cfg_we && (int'(cfg_addr) < M_COUNT)) begin
         ruleValid_q[cfg_addr] <= cfg_rule_valid;
         ruleType_q[cfg_addr]  <= cfg_ethertype;
      end
   end

   // Priority match: scanning from the top down leaves the lowest matching index.
   always_comb begin
      matchHit = 1'b0;
      matchIdx = '0;
      for (int i = M_COUNT - 1; i >= 0; i--) begin
         if (ruleValid_q[i] && (ruleType_q[i] == s_eth_type)) begin
            matchHit = 1'b1;
            matchIdx = SEL_W'(i);
         end
      end
   end

   // Frame state machine: decide in IDLE, wait for header accept, run to tlast.
   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      drop_d   = drop_q;
      case (state_q)
         IDLE: begin
            if (s_eth_hdr_valid && ctrl_enable) begin
               select_d = matchHit ? matchIdx : DEF_SEL;
               drop_d   = matchHit ? 1'b0 : DEF_DROP;
               state_d  = ARMED;
            end
         end
         ARMED: begin
            if (hdrAccept) begin
               state_d = FRAME;
            end
         end
         FRAME: begin
            if (tlastAccept) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Decision and state registers; the decision is only reloaded from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         select_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         drop_q   <= drop_d;
      end
   end

   assign enable = (state_q != IDLE);
   assign busy   = (state_q != IDLE);
   assign select = select_q;
   assign drop   = drop_q;

`ifdef ETH_DEMUX_SEL_CTRL_STATS_EN
   logic [CNT_WIDTH-1:0] frameCnt_q [M_COUNT];
   logic [CNT_WIDTH-1:0] dropCnt_q;

   // Saturating statistics; a clear wins over a coincident increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < M_COUNT; i++) begin
            frameCnt_q[i] <= '0;
         end
         dropCnt_q <= '0;
      end else if (stats_clear) begin
         for (int i = 0; i < M_COUNT; i++) begin
            frameCnt_q[i] <= '0;
         end
         dropCnt_q <= '0;
      end else if (countEvent) begin
         if (drop_q) begin
            if (dropCnt_q != '1) begin
               dropCnt_q <= dropCnt_q + CNT_WIDTH'(1);
            end
         end else if (frameCnt_q[select_q] != '1) begin
            frameCnt_q[select_q] <= frameCnt_q[select_q] + CNT_WIDTH'(1);
         end
      end
   end

   for (genvar g = 0; g < M_COUNT; g++) begin : gCountOut
      assign frame_count[g*CNT_WIDTH +: CNT_WIDTH] = frameCnt_q[g];
   end
   assign drop_count = dropCnt_q;
`else
   logic unusedStats;
   assign unusedStats = stats_clear ^ countEvent;
   assign frame_count = '0;
   assign drop_count  = '0;
`endif

endmodule
